// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register-access sequencer.
// Holds the FSM state enum, register map addresses and the map check.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_ACCESS,
        S_RESP
    } seq_state_t;

    localparam logic [3:0] ADR_CTRL0 = 4'h0;
    localparam logic [3:0] ADR_CTRL1 = 4'h1;
    localparam logic [3:0] ADR_CTRL2 = 4'h2;
    localparam logic [3:0] ADR_DATA1 = 4'h8;
    localparam logic [3:0] ADR_DATA2 = 4'h9;
    localparam logic [3:0] ADR_DATA3 = 4'hA;
    localparam logic [3:0] ADR_DATA4 = 4'hB;
    localparam logic [3:0] ADR_DATA5 = 4'hC;
    localparam logic [3:0] ADR_DATA6 = 4'hD;
    localparam logic [3:0] ADR_DATA7 = 4'hE;
    localparam logic [3:0] ADR_DATA8 = 4'hF;

    // CTRL0..CTRL2 and DATA1..DATA8 decode; 3..7 are holes.
    function automatic logic adr_mapped(input logic [3:0] addr);
        return (addr <= ADR_CTRL2) || (addr >= ADR_DATA1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-grant flag.
// The flag only moves when the sequencer actually takes a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Tie goes to the port that did not win last time.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last_q);
        gnt[1] = req[1] & (~req[0] | ~last_q);
    end

    // Remember the winner of each taken grant.
    always_comb begin
        last_d = last_q;
        if (en && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    // Reset as if port 1 won last, so port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/reg_access_seq.sv
// Register-access sequencer: arbitrates two ports and runs
// ADDR/LATCH/ACCESS/RESP. Optional read bursts under REG_BURST_EN.
module reg_access_seq
    import reg_seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [7:0]          req_addr,
    input  logic [1:0]          req_we,
    input  logic [2*DATA_W-1:0] req_wdata,
`ifdef REG_BURST_EN
    input  logic [5:0]          req_len,
`endif
    output logic [3:0]          reg_adr,
    output logic                adr_latch,
    output logic                reg_en,
    output logic                reg_we,
    output logic [DATA_W-1:0]   reg_wdata,
    input  logic [DATA_W-1:0]   reg_rdata,
    output logic                rsp_valid,
    output logic                rsp_port,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam logic [2:0] WAIT_L = 3'(WAIT_CYC);

    seq_state_t state_q, state_d;

    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [3:0]        adr_q, adr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef REG_BURST_EN
    logic [2:0]        beat_q, beat_d;
    logic [2:0]        len_sel;
`endif

    logic [1:0]        gnt;
    logic              gnt_en;
    logic              sel;
    logic [3:0]        addr_sel;
    logic              we_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              bad_sel;
    logic              last_acc;
    logic              more_beats;

    assign gnt_en = (state_q == S_IDLE) && (req_valid != 2'b00);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (gnt_en),
        .gnt   (gnt)
    );

    // Mux the granted port's request fields and classify it.
    always_comb begin
        sel       = gnt[1];
        addr_sel  = sel ? req_addr[7:4] : req_addr[3:0];
        we_sel    = sel ? req_we[1] : req_we[0];
        wdata_sel = sel ? req_wdata[2*DATA_W-1:DATA_W]
                        : req_wdata[DATA_W-1:0];
        bad_sel   = !adr_mapped(addr_sel);
`ifdef REG_BURST_EN
        len_sel   = sel ? req_len[5:3] : req_len[2:0];
        if ((len_sel != 3'd0) &&
            (we_sel || (addr_sel < ADR_DATA1))) begin
            bad_sel = 1'b1;
        end
`endif
    end

    assign last_acc = (cnt_q == WAIT_L);

`ifdef REG_BURST_EN
    assign more_beats = (beat_q != 3'd0);
`else
    assign more_beats = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the access sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) state_d = S_ADDR;
            end
            S_ADDR:   state_d = S_LATCH;
            S_LATCH:  state_d = err_q ? S_RESP : S_ACCESS;
            S_ACCESS: begin
                if (last_acc) state_d = S_RESP;
            end
            S_RESP:   state_d = more_beats ? S_ADDR : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Capture the granted request, count wait states, sample reads.
    always_comb begin
        port_d  = port_q;
        we_d    = we_q;
        err_d   = err_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = 3'd0;
`ifdef REG_BURST_EN
        beat_d  = beat_q;
`endif
        if (gnt_en) begin
            port_d  = sel;
            we_d    = we_sel;
            err_d   = bad_sel;
            adr_d   = addr_sel;
            wdata_d = wdata_sel;
            rdata_d = '0;
`ifdef REG_BURST_EN
            beat_d  = bad_sel ? 3'd0 : len_sel;
`endif
        end
        if (state_q == S_ACCESS) begin
            if (!last_acc) begin
                cnt_d = cnt_q + 3'd1;
            end else if (!we_q) begin
                rdata_d = reg_rdata;
            end
        end
`ifdef REG_BURST_EN
        // Next burst beat walks DATA1..DATA8, wrapping 15 to 8.
        if ((state_q == S_RESP) && more_beats) begin
            adr_d   = {1'b1, adr_q[2:0] + 3'd1};
            beat_d  = beat_q - 3'd1;
            rdata_d = '0;
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= 4'd0;
            cnt_q   <= 3'd0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef REG_BURST_EN
            beat_q  <= 3'd0;
`endif
        end else begin
            port_q  <= port_d;
            we_q    <= we_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef REG_BURST_EN
            beat_q  <= beat_d;
`endif
        end
    end

    // Bus and response outputs decoded from the current state.
    always_comb begin
        req_ready = gnt_en ? gnt : 2'b00;
        reg_adr   = adr_q;
        reg_wdata = wdata_q;
        adr_latch = (state_q == S_ADDR);
        reg_en    = (state_q == S_ACCESS);
        reg_we    = (state_q == S_ACCESS) && we_q && last_acc;
        rsp_valid = (state_q == S_RESP);
        rsp_port  = rsp_valid && port_q;
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = rsp_valid ? rdata_q : '0;
    end

endmodule

// File: doc/reg_access_seq.md
# reg_access_seq

Register-access sequencer that drives the address-latch / register-select bus of the peripheral register file (CTRL0–CTRL2, DATA1–DATA8). It arbitrates between two requesters (host port 0, auxiliary port 1) round-robin. For each granted request it sequences the address phase, the latch strobe, the enable window with programmable wait states, and the response. It sits between the host interface logic and the address decoder / register bank.

## Interface
- `DATA_W`, default 8: register data width.
- `WAIT_CYC`, default 1: extra enable cycles after the first (0–7).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain; reset is asynchronous and active-low.
- `req_valid` in 2: per-port request valid, bit i = port i.
- `req_ready` out 2: per-port accept, one-hot pulse.
- `req_addr` in 2×4: per-port register address.
- `req_we` in 2: per-port write enable.
- `req_wdata` in 2×DATA_W: per-port write data.
- `req_len` in 2×3: per-port read burst length minus 1. Present only with REG_BURST_EN.
- `reg_adr` out 4: address to the decoder.
- `adr_latch` out 1: latch strobe. The decoder captures on its falling edge.
- `reg_en` out 1: decoder output enable.
- `reg_we` out 1: write strobe to the register bank.
- `reg_wdata` out DATA_W: write data.
- `reg_rdata` in DATA_W: read data from the selected register.
- `rsp_valid` out 1: response valid, one cycle.
- `rsp_port` out 1: port that owns the response.
- `rsp_rdata` out DATA_W: read data. Zero for writes and errors.
- `rsp_err` out 1: unmapped address (3–7), or illegal burst.

## Operation
- FSM states: IDLE, ADDR, LATCH, ACCESS, RESP.
- IDLE, on any req_valid:
  - Grant one port and pulse its req_ready for one cycle.
  - Capture addr, we, wdata (and len).
  - Go to ADDR.
- Round-robin arbitration:
  - A single valid request is granted.
  - If both ports are valid, grant the port not granted last.
  - After reset, port 0 wins the first tie.
- ADDR: drive reg_adr = captured addr; adr_latch = 1.
- LATCH: adr_latch = 0; the decoder latches on this edge.
  - Unmapped address (3–7): go to RESP with rsp_err = 1. reg_en never asserts.
  - Otherwise go to ACCESS.
- ACCESS: reg_en = 1 for WAIT_CYC+1 cycles, counted by a 3-bit counter.
  - Write: reg_we = 1 on the last ACCESS cycle only.
  - Read: reg_rdata is sampled on the last ACCESS cycle.
- RESP: rsp_valid = 1 for one cycle, with rsp_port, rsp_rdata, rsp_err; then IDLE.
- No backpressure on the response. The consumer must accept every rsp_valid.
- reg_adr and reg_wdata hold their value until the next ADDR state.

## Timing
- Reset values: req_ready = 0, reg_adr = 0, adr_latch = 0, reg_en = 0, reg_we = 0, reg_wdata = 0, rsp_valid = 0, rsp_port = 0, rsp_rdata = 0, rsp_err = 0. The arbiter's last-grant flag = port 1, so port 0 wins first.
- Cycle numbering from the accept cycle (cycle 0):
  - ADDR at cycle 1, LATCH at cycle 2.
  - ACCESS at cycles 3 to 3+WAIT_CYC.
  - RESP at cycle 4+WAIT_CYC.
- Latency to rsp_valid is 4+WAIT_CYC cycles for a mapped access and 3 cycles for an error.
- No new request is accepted until the cycle after RESP (IDLE). Maximum throughput is one access per 5+WAIT_CYC cycles.
- req_valid may drop at any time before it is granted; nothing is latched in that case.
- rst_n asserted in any state:
  - Outputs clear immediately.
  - The in-flight access is dropped with no response.
  - The FSM returns to IDLE.

## Configuration
- `REG_BURST_EN` defined:
  - The req_len ports exist.
  - A read to DATA1–DATA8 (addr 8–15) performs req_len+1 beats. Each beat is ADDR→LATCH→ACCESS→RESP.
  - The address increments per beat and wraps 15→8.
  - Arbitration is held for the whole burst.
  - A burst with req_len>0 and either a write or an address below 8 responds with a single rsp_err beat and no access.
- `REG_BURST_EN` undefined: the req_len ports are absent and every request is a single beat.

## Structure
- Package `reg_seq_pkg`:
  - FSM state enum.
  - Address constants ADR_CTRL0..ADR_CTRL2 and ADR_DATA1..ADR_DATA8.
  - Function `adr_mapped(addr)`.
- Sub-module `rr_arbiter2`:
  - Two-request round-robin arbiter with a last-grant flop.
  - Updates only on a grant enable from the FSM.

## Test plan
- Port 0 writes 0xA5 to addr 0x9 with WAIT_CYC=1 → adr_latch high at cycle 1; reg_en at cycles 3–4; reg_we only at cycle 4 with reg_wdata = 0xA5; rsp_valid at cycle 5 with rsp_port = 0, rsp_err = 0.
- Port 1 reads addr 0x2 with reg_rdata = 0x3C → rsp_rdata = 0x3C, rsp_port = 1 at cycle 5.
- Both ports valid for three consecutive accesses after reset → grants in order port 0, port 1, port 0.
- Read of addr 0x5 → reg_en never asserts; rsp_err = 1 at cycle 3; rsp_rdata = 0.
- rst_n pulsed low during ACCESS → all outputs zero within the reset; no rsp_valid; next request behaves normally.
- With REG_BURST_EN: read addr 0xE, len 2 → beats at addresses 0xE, 0xF, 0x8; three rsp_valid pulses; the other port is not granted until after the third beat.
